// File: rtl/nios_fprint_scratchpad_arbiter_if.sv
// Purpose: one Avalon-MM master port into the scratchpad arbiter.
// Latency: none; this file only bundles the request, response and read-return signals.
// Backpressure: the slave raises waitrequest, and the master holds its request until waitrequest drops.
interface nios_fprint_scratchpad_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic                  chipselect;
  logic                  read;
  logic                  write;
  logic [ADDR_W-1:0]     address;
  logic [DATA_W/8-1:0]   byteenable;
  logic [DATA_W-1:0]     writedata;
  logic                  waitrequest;
  logic [DATA_W-1:0]     readdata;
  logic                  readdatavalid;

  modport master (
    output chipselect, read, write, address, byteenable, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  chipselect, read, write, address, byteenable, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/nios_fprint_scratchpad_arbiter.sv
// Purpose: shares one single-port scratchpad between the CPU data master (a) and the fingerprint DMA (b).
// Latency: the grant issues to the RAM in the same cycle, and read data returns exactly one cycle later.
// Backpressure: the losing or idle port sees waitrequest=1; round-robin caps a port's streak at MAX_GRANT.
module nios_fprint_scratchpad_arbiter #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int MAX_GRANT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  nios_fprint_scratchpad_arbiter_if.slave a,
  nios_fprint_scratchpad_arbiter_if.slave b,
  output logic [ADDR_W-1:0]      sp_address,
  output logic [DATA_W/8-1:0]    sp_byteenable,
  output logic                   sp_chipselect,
  output logic                   sp_write,
  output logic [DATA_W-1:0]      sp_writedata,
  output logic                   sp_clken,
  input  logic [DATA_W-1:0]      sp_readdata
);

  typedef enum logic {OWN_A = 1'b0, OWN_B = 1'b1} own_e;

  localparam logic [3:0] MAX_CNT = 4'(MAX_GRANT);

  own_e       r_owner, w_owner_nxt;
  own_e       r_last_owner, w_last_owner_nxt;
  logic [3:0] r_grant_cnt, w_grant_cnt_nxt;
  logic       r_rd_pend, w_rd_pend_nxt;
  own_e       r_rd_owner, w_rd_owner_nxt;

  logic       w_req_a, w_req_b;
  logic       w_gnt_vld;
  own_e       w_winner;
  logic       w_sel_b;
  logic       w_win_write;
  logic       w_gnt_rd;

  // A read and a write asserted together count as one request; the write takes precedence.
  assign w_req_a = a.chipselect & (a.read | a.write);
  assign w_req_b = b.chipselect & (b.read | b.write);

  // Pick the winner. After an idle cycle the streak is zero, so the port that did not go last wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_winner  = OWN_A;
    if (!reset) begin
      if (w_req_a && !w_req_b) begin
        w_gnt_vld = 1'b1;
        w_winner  = OWN_A;
      end else if (w_req_b && !w_req_a) begin
        w_gnt_vld = 1'b1;
        w_winner  = OWN_B;
      end else if (w_req_a && w_req_b) begin
        w_gnt_vld = 1'b1;
        if (r_grant_cnt == 4'd0) begin
          w_winner = own_e'(~r_last_owner);
        end else if (r_grant_cnt < MAX_CNT) begin
          w_winner = r_owner;
        end else begin
          w_winner = own_e'(~r_owner);
        end
      end
    end
  end

  assign w_sel_b     = (w_winner == OWN_B);
  assign w_win_write = w_sel_b ? b.write : a.write;
  assign w_gnt_rd    = w_gnt_vld & ~w_win_write;

  // The winner's request goes straight through to the RAM, with no registering on the issue path.
  assign sp_chipselect = w_gnt_vld;
  assign sp_write      = w_gnt_vld & w_win_write;
  assign sp_address    = w_sel_b ? b.address    : a.address;
  assign sp_byteenable = w_sel_b ? b.byteenable : a.byteenable;
  assign sp_writedata  = w_sel_b ? b.writedata  : a.writedata;
  assign sp_clken      = 1'b1;

  assign a.waitrequest = ~(w_gnt_vld & (w_winner == OWN_A));
  assign b.waitrequest = ~(w_gnt_vld & (w_winner == OWN_B));

  // Read data is shared by both ports, and readdatavalid selects which port it belongs to.
  // Gating readdatavalid with reset drops a read that is in flight when reset arrives.
  assign a.readdata      = sp_readdata;
  assign b.readdata      = sp_readdata;
  assign a.readdatavalid = r_rd_pend & (r_rd_owner == OWN_A) & ~reset;
  assign b.readdatavalid = r_rd_pend & (r_rd_owner == OWN_B) & ~reset;

  // Next state: extend or restart the owner's streak on a grant, clear it on an idle cycle,
  // and track the read that is in flight.
  always_comb begin
    w_owner_nxt      = r_owner;
    w_last_owner_nxt = r_last_owner;
    w_grant_cnt_nxt  = r_grant_cnt;
    w_rd_pend_nxt    = w_gnt_rd;
    w_rd_owner_nxt   = r_rd_owner;
    if (w_gnt_vld) begin
      if (w_winner == r_owner) begin
        w_grant_cnt_nxt = (r_grant_cnt == 4'hF) ? r_grant_cnt : r_grant_cnt + 4'd1;
      end else begin
        w_owner_nxt     = w_winner;
        w_grant_cnt_nxt = 4'd1;
      end
      w_last_owner_nxt = w_winner;
    end else begin
      w_grant_cnt_nxt = 4'd0;
    end
    if (w_gnt_rd) begin
      w_rd_owner_nxt = w_winner;
    end
  end

  // State register. Reset makes B the owner and last owner, so the first contended grant goes to A.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner      <= OWN_B;
      r_last_owner <= OWN_B;
      r_grant_cnt  <= 4'd0;
      r_rd_pend    <= 1'b0;
      r_rd_owner   <= OWN_A;
    end else begin
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_owner_nxt;
      r_grant_cnt  <= w_grant_cnt_nxt;
      r_rd_pend    <= w_rd_pend_nxt;
      r_rd_owner   <= w_rd_owner_nxt;
    end
  end

endmodule

// File: tb/tb_nios_fprint_scratchpad_arbiter.sv
// Purpose: bench for the scratchpad arbiter, with a RAM stand-in and a transaction-level reference model.
// Latency: inputs are driven 1ns after each rising edge, and outputs are sampled 4ns after the edge.
// Backpressure: a port that loses arbitration keeps the same request until the model says it won.
module tb_nios_fprint_scratchpad_arbiter;
  localparam int MAXG = 4;

  typedef struct packed {
    logic        cs;
    logic        rd;
    logic        wr;
    logic [11:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } req_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] sp_address;
  logic [3:0]  sp_byteenable;
  logic        sp_chipselect, sp_write, sp_clken;
  logic [31:0] sp_writedata;
  logic [31:0] sp_readdata;

  logic        ld_vld = 1'b0;
  logic [11:0] ld_addr = '0;
  logic [31:0] ld_dat = '0;
  logic [31:0] mem [4096];

  nios_fprint_scratchpad_arbiter_if #(.ADDR_W(12), .DATA_W(32)) ia ();
  nios_fprint_scratchpad_arbiter_if #(.ADDR_W(12), .DATA_W(32)) ib ();

  nios_fprint_scratchpad_arbiter #(.ADDR_W(12), .DATA_W(32), .MAX_GRANT(MAXG)) dut (
    .clk           (clk),
    .reset         (reset),
    .a             (ia),
    .b             (ib),
    .sp_address    (sp_address),
    .sp_byteenable (sp_byteenable),
    .sp_chipselect (sp_chipselect),
    .sp_write      (sp_write),
    .sp_writedata  (sp_writedata),
    .sp_clken      (sp_clken),
    .sp_readdata   (sp_readdata)
  );

  always #5 clk = ~clk;

  // Single-port RAM stand-in. Its q output is registered, so read data appears the cycle after the address.
  always @(posedge clk) begin
    if (ld_vld) begin
      mem[ld_addr] <= ld_dat;
    end else if (sp_chipselect && sp_clken) begin
      if (sp_write) begin
        for (int k = 0; k < 4; k++)
          if (sp_byteenable[k]) mem[sp_address][8*k +: 8] <= sp_writedata[8*k +: 8];
      end else begin
        sp_readdata <= mem[sp_address];
      end
    end
  end

  // Reference model: a shadow memory, the previous winner, the length of its current streak,
  // and the read expected back in the next cycle.
  logic [31:0] ref_mem [4096];
  int          m_last = 1;
  int          m_streak = 0;
  int          m_rdv = -1;
  logic [31:0] m_rdat = '0;

  int n_chk = 0;
  int n_err = 0;

  int          s_win;
  logic        s_a_wait, s_a_rdv, s_b_rdv;
  logic [31:0] s_a_rdat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic req_t mk(input logic rd, input logic wr, input logic [11:0] addr,
                              input logic [3:0] be, input logic [31:0] wd);
    req_t r;
    r.cs = 1'b1; r.rd = rd; r.wr = wr; r.addr = addr; r.be = be; r.wd = wd;
    return r;
  endfunction

  function automatic logic is_req(input req_t r);
    return r.cs & (r.rd | r.wr);
  endfunction

  // Runs one clock cycle: drive the inputs, check the outputs against the model, then advance the model.
  task automatic step(input req_t ra, input req_t rb, input logic rst, output int won);
    int   ew;
    logic qa, qb;
    req_t wr_req;
    @(posedge clk); #1;
    reset = rst;
    ia.chipselect = ra.cs; ia.read = ra.rd; ia.write = ra.wr;
    ia.address = ra.addr; ia.byteenable = ra.be; ia.writedata = ra.wd;
    ib.chipselect = rb.cs; ib.read = rb.rd; ib.write = rb.wr;
    ib.address = rb.addr; ib.byteenable = rb.be; ib.writedata = rb.wd;
    #3;
    qa = is_req(ra);
    qb = is_req(rb);
    if (rst || (!qa && !qb)) ew = 2;
    else if (qa && !qb) ew = 0;
    else if (qb && !qa) ew = 1;
    else if (m_streak == 0) ew = 1 - m_last;
    else if (m_streak < MAXG) ew = m_last;
    else ew = 1 - m_last;

    chk("a_waitrequest", 32'(ia.waitrequest), 32'(ew != 0));
    chk("b_waitrequest", 32'(ib.waitrequest), 32'(ew != 1));
    chk("sp_chipselect", 32'(sp_chipselect), 32'(ew != 2));
    if (ew != 2) begin
      wr_req = (ew == 0) ? ra : rb;
      chk("sp_address", 32'(sp_address), 32'(wr_req.addr));
      chk("sp_write", 32'(sp_write), 32'(wr_req.wr));
      if (wr_req.wr) begin
        chk("sp_writedata", sp_writedata, wr_req.wd);
        chk("sp_byteenable", 32'(sp_byteenable), 32'(wr_req.be));
      end
    end
    chk("a_readdatavalid", 32'(ia.readdatavalid), 32'(!rst && m_rdv == 0));
    chk("b_readdatavalid", 32'(ib.readdatavalid), 32'(!rst && m_rdv == 1));
    if (!rst && m_rdv == 0) chk("a_readdata", ia.readdata, m_rdat);
    if (!rst && m_rdv == 1) chk("b_readdata", ib.readdata, m_rdat);
    chk("sp_clken", 32'(sp_clken), 32'd1);

    s_win    = !ia.waitrequest ? 0 : (!ib.waitrequest ? 1 : 2);
    s_a_wait = ia.waitrequest;
    s_a_rdv  = ia.readdatavalid;
    s_b_rdv  = ib.readdatavalid;
    s_a_rdat = ia.readdata;

    if (rst) begin
      m_last = 1; m_streak = 0; m_rdv = -1;
    end else if (ew == 2) begin
      m_streak = 0; m_rdv = -1;
    end else begin
      m_streak = (ew == m_last) ? m_streak + 1 : 1;
      m_last = ew;
      wr_req = (ew == 0) ? ra : rb;
      if (wr_req.wr) begin
        for (int k = 0; k < 4; k++)
          if (wr_req.be[k]) ref_mem[wr_req.addr][8*k +: 8] = wr_req.wd[8*k +: 8];
        m_rdv = -1;
      end else begin
        m_rdv = ew;
        m_rdat = ref_mem[wr_req.addr];
      end
    end
    won = ew;
  endtask

  task automatic preload(input logic [11:0] addr, input logic [31:0] dat);
    @(posedge clk); #1;
    ld_vld = 1'b1; ld_addr = addr; ld_dat = dat;
    ref_mem[addr] = dat;
  endtask

  function automatic req_t rnd_req();
    req_t r;
    int   sel;
    sel = $urandom_range(0, 9);
    r = mk(1'b0, 1'b0, 12'($urandom_range(0, 31)), 4'($urandom_range(0, 15)), $urandom);
    if (sel < 4) begin
      r.cs = 1'($urandom_range(0, 1));
      r.rd = (sel == 0);
      r.wr = (sel == 1);
      if (sel < 2) r.cs = 1'b0;
    end else if (sel < 7) begin
      r.rd = 1'b1;
    end else if (sel < 9) begin
      r.wr = 1'b1;
    end else begin
      r.rd = 1'b1; r.wr = 1'b1;
    end
    return r;
  endfunction

  initial begin
    req_t idle;
    req_t ca, cb;
    int   w;
    int   cnt;
    logic hold_a, hold_b, rst;
    int   drop_seq [7];
    drop_seq = '{0, 0, 1, 1, 1, 1, 0};
    idle = '0;

    reset = 1'b1;
    for (int i = 0; i < 32; i++) preload(12'(i), $urandom);
    preload(12'h010, 32'hDEADBEEF);
    preload(12'h0FF, 32'hAABBCCDD);
    @(posedge clk); #1;
    ld_vld = 1'b0;

    // Reset values, then a single read from A.
    step(idle, idle, 1'b1, w);
    step(idle, idle, 1'b0, w);
    step(mk(1'b1, 1'b0, 12'h010, 4'hF, 32'h0), idle, 1'b0, w);
    chk("first_read_wait", 32'(s_a_wait), 32'd0);
    step(idle, idle, 1'b0, w);
    chk("first_read_rdv_a", 32'(s_a_rdv), 32'd1);
    chk("first_read_data", s_a_rdat, 32'hDEADBEEF);
    chk("first_read_rdv_b", 32'(s_b_rdv), 32'd0);

    // Continuous contention right after reset: the grants go AAAA then BBBB, repeating.
    step(idle, idle, 1'b1, w);
    for (int i = 0; i < 12; i++) begin
      step(mk(1'b1, 1'b0, 12'h010, 4'hF, 32'h0), mk(1'b1, 1'b0, 12'h011, 4'hF, 32'h0), 1'b0, w);
      chk("rr_order", 32'(s_win), 32'((i / MAXG) % 2));
    end
    step(idle, idle, 1'b0, w);

    // A byte-enabled write from B, then A reads back the merged word.
    step(idle, mk(1'b0, 1'b1, 12'h0FF, 4'h3, 32'h12345678), 1'b0, w);
    step(mk(1'b1, 1'b0, 12'h0FF, 4'hF, 32'h0), idle, 1'b0, w);
    step(idle, idle, 1'b0, w);
    chk("be_merge", s_a_rdat, 32'hAABB5678);

    // A drops out after two grants. B takes over with a fresh streak and keeps it for MAX_GRANT grants.
    step(idle, idle, 1'b1, w);
    for (int i = 0; i < 7; i++) begin
      ca = (i == 2) ? idle : mk(1'b1, 1'b0, 12'h004, 4'hF, 32'h0);
      step(ca, mk(1'b1, 1'b0, 12'h005, 4'hF, 32'h0), 1'b0, w);
      chk("drop_order", 32'(s_win), 32'(drop_seq[i]));
    end
    step(idle, idle, 1'b0, w);

    // Reset in the cycle after a granted read: the in-flight read must never be returned.
    step(mk(1'b1, 1'b0, 12'h006, 4'hF, 32'h0), idle, 1'b0, w);
    step(mk(1'b1, 1'b0, 12'h007, 4'hF, 32'h0), idle, 1'b1, w);
    chk("rst_drop_rdv_a", 32'(s_a_rdv), 32'd0);
    step(idle, idle, 1'b0, w);
    chk("post_rst_rdv_a", 32'(s_a_rdv), 32'd0);

    // B alternates write and read while A is idle: one readdatavalid per read, none per write.
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) step(idle, mk(1'b0, 1'b1, 12'(i), 4'hF, 32'(i * 32'h01010101)), 1'b0, w);
      else            step(idle, mk(1'b1, 1'b0, 12'(i - 1), 4'hF, 32'h0), 1'b0, w);
      chk("alt_b_won", 32'(w), 32'd1);
      cnt += int'(s_b_rdv);
    end
    step(idle, idle, 1'b0, w);
    cnt += int'(s_b_rdv);
    chk("alt_b_rdv_count", 32'(cnt), 32'd4);

    // Random traffic, with the occasional reset.
    hold_a = 1'b0; hold_b = 1'b0;
    ca = idle; cb = idle;
    for (int n = 0; n < 600; n++) begin
      if (!hold_a) ca = rnd_req();
      if (!hold_b) cb = rnd_req();
      rst = ($urandom_range(0, 59) == 0);
      step(ca, cb, rst, w);
      hold_a = is_req(ca) && (w != 0);
      hold_b = is_req(cb) && (w != 1);
    end
    step(idle, idle, 1'b0, w);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/nios_fprint_scratchpad_arbiter.md
# nios_fprint_scratchpad_arbiter

Two-port arbiter that shares one single-port 4096 x 32 scratchpad RAM between the processor data master (port A) and the fingerprint DMA master (port B). Sits between the two Avalon-MM masters and the scratchpad slave inside each processor tile. Grants one transfer per cycle with bounded round-robin fairness. Returns read data with fixed one-cycle latency, flagged by readdatavalid.

## Interface
- ADDR_W, 12, word address width (4096 words)
- DATA_W, 32, data width; byteenable width is DATA_W/8
- MAX_GRANT, 4, max consecutive transfers granted to one port while the other is requesting (1..15)

- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- a_chipselect, a_read, a_write  in  1 each  port A request qualifiers
- a_address  in  ADDR_W  port A word address
- a_byteenable  in  DATA_W/8  port A byte lanes
- a_writedata  in  DATA_W  port A write data
- a_waitrequest  out  1  high = port A transfer not accepted this cycle
- a_readdata  out  DATA_W  port A read data
- a_readdatavalid  out  1  a_readdata valid this cycle
- b_*  same set as port A, for port B
- sp_address  out  ADDR_W  to scratchpad
- sp_byteenable  out  DATA_W/8  to scratchpad
- sp_chipselect, sp_write  out  1 each  to scratchpad
- sp_writedata  out  DATA_W  to scratchpad
- sp_clken  out  1  scratchpad clock enable, tied 1
- sp_readdata  in  DATA_W  scratchpad q, valid the cycle after address issue

## Operation
- Request on port X: x_chipselect & (x_read | x_write). Read and write together is illegal; write wins.
- State: owner (A/B), last_owner, grant_cnt (4 bits), rd_pend, rd_owner.
- Grant, combinational from state and requests:
  - one requester: it wins.
  - both requesting, owner still requesting, grant_cnt < MAX_GRANT: owner wins.
  - both requesting otherwise: the non-owner wins.
  - none requesting: no grant, sp_chipselect = 0.
- Winner: waitrequest 0; sp_* driven from its inputs. Loser: waitrequest 1, must hold its request.
- A non-requesting port sees waitrequest 1.
- Registered update on a granted cycle:
  - winner == owner: grant_cnt saturating +1.
  - else: owner <= winner, grant_cnt <= 1.
  - last_owner <= winner.
- Idle cycle: grant_cnt <= 0; owner unchanged.
- Both requesting with grant_cnt = 0 (first cycle after idle or reset): the port opposite last_owner wins.
- Granted read: rd_pend <= 1, rd_owner <= winner. Otherwise rd_pend <= 0.
- Read return: x_readdatavalid = rd_pend & (rd_owner == X). Both a_readdata and b_readdata are driven from sp_readdata unconditionally.
- Reads are pipelined: back-to-back granted reads give back-to-back readdatavalid, in issue order.
- Write needs no response. A write issued the cycle after a read does not disturb that read's return.
- Reset values: owner = B, last_owner = B, grant_cnt = 0, rd_pend = 0, both readdatavalid 0, sp_chipselect 0, both waitrequest 1 while reset is high.
- With this reset state, simultaneous first requests go to A.
- Reset mid-operation: a pending read is dropped and no readdatavalid is issued. The master re-issues it.

## Timing
- Issue: a request granted in cycle T reaches the scratchpad in cycle T (combinational path, no added latency).
- Read latency: exactly 1 cycle; readdatavalid and readdata appear at T+1.
- Throughput: 1 transfer/cycle aggregate.
- Fairness: under continuous contention, a port waits at most MAX_GRANT cycles.
- Alternating pattern under contention: MAX_GRANT transfers to A, then MAX_GRANT to B.
- Combinational paths: request inputs -> waitrequest and request inputs -> sp_*. No path from sp_readdata to waitrequest.

## Test plan
- Reset, then A reads address 0x010 (RAM preloaded with 0xDEADBEEF): a_waitrequest 0 in cycle T; a_readdatavalid = 1 with 0xDEADBEEF in T+1; b_readdatavalid stays 0.
- A and B issue continuous reads from the same cycle with MAX_GRANT = 4: grants go A,A,A,A,B,B,B,B,A…; each readdatavalid lands on the correct port one cycle after its grant.
- B writes 0x12345678 to 0x0FF with byteenable 0x3, then A reads 0x0FF: low half-word updated, upper bytes unchanged.
- Contention in which A drops its request after 2 grants: B is granted on the next cycle; grant_cnt restarts at 1.
- Reset asserted in the cycle after a granted read: no readdatavalid on either port; all outputs at their reset values one cycle later.
- Write and read on port B in alternating cycles while A is idle: B never sees waitrequest; exactly one readdatavalid per read, none per write.
